noc_out_arbiter: RTL and testbench
==================================

# noc_out_arbiter

Round-robin output-port arbiter and serializer for the NoC router. It shares one outbound 8-bit serial link among `NUM_IN` input buffers, which are FIFOs presenting packets with combinational read data. It grants one requester, pops that requester's packet with a one-cycle ack, and sends the packet as 4 bytes on the put/free link that the node endpoints use. One instance sits on each router output port, between the input-buffer FIFOs and the downstream node or router.

## Interface
Parameters:
- `NUM_IN`, 4, number of requesting input buffers (1..8)
- `CNT_W`, 16, width of each grant statistics counter (only used with `ARB_STATS_EN`)

Ports:
- `clk`  in  1  system clock
- `rst_b`  in  1  reset: one clock; reset is synchronous and active-low
- `pkt_in`  in  `NUM_IN`x32 (pkt_t array)  head packet of each input buffer
- `pkt_valid`  in  `NUM_IN`  input buffer i is non-empty
- `pkt_ack`  out  `NUM_IN`  one-hot, one-cycle pop strobe to the winning buffer
- `gnt_id`  out  $clog2(`NUM_IN`) (min 1)  index of the current or last winner
- `busy`  out  1  a packet is held or being sent
- `free`  in  1  downstream can accept a packet
- `put`  out  1  byte on `payload` is valid
- `payload`  out  8  serial byte
- `grant_cnt`  out  `NUM_IN`x`CNT_W`  per-port grant counters

## Operation
- FSM states: IDLE, WAIT, SEND.
- **IDLE**
  - If any `pkt_valid` is set, the round-robin picker selects a winner w.
  - `pkt_ack[w]`=1 in the same cycle.
  - `pkt_in[w]` latches into a 32-bit buffer at the edge.
  - `gnt_id`<=w and the pointer <=w.
  - Next state is WAIT.
  - If no `pkt_valid` is set, stay in IDLE with `pkt_ack`=0.
- **WAIT**
  - `busy`=1, `put`=0.
  - Move to SEND at the edge where `free`=1.
  - `free` is sampled only in WAIT, so a mid-packet drop of `free` is ignored.
- **SEND**
  - `put`=1 for exactly 4 consecutive cycles.
  - A 2-bit counter `cnt` selects the byte: 0 is [31:24], 1 is [23:16], 2 is [15:8], 3 is [7:0].
  - At `cnt`==3, go to IDLE and clear `cnt`.
- **Round robin**
  - Search order starts at pointer+1 and wraps modulo `NUM_IN`.
  - Reset pointer = `NUM_IN`-1, so port 0 has first priority.
  - Pointer wrap at `NUM_IN`-1 goes to 0.
  - A port with continuous `pkt_valid` cannot win twice in a row while another port is valid.
- **Other rules**
  - `pkt_ack` is never asserted to a port whose `pkt_valid`=0.
  - At most one `pkt_ack` bit is set per cycle.
  - `payload`=8'h00 whenever `put`=0.
  - A `pkt_valid` change during WAIT/SEND has no effect; only IDLE samples requests.
  - `NUM_IN`=1: the picker degenerates to pass-through; `gnt_id` is always 0.

## Timing
- Reset values: state=IDLE, `put`=0, `payload`=0, `pkt_ack`=0, `busy`=0, `gnt_id`=0, pointer=`NUM_IN`-1, `cnt`=0, buffer=0, `grant_cnt`=0.
- Reset mid-packet: at the next edge `put` drops and the packet is discarded (not re-sent). The downstream sees a truncated burst.
- Latency with `free` held high:
  - `pkt_valid` seen in IDLE at cycle t gives `pkt_ack` in t.
  - WAIT in t+1; first `put` in t+2; last byte in t+5; IDLE in t+6.
- Back-to-back packets: 6-cycle period per packet.
- At least 2 cycles with `put`=0 (IDLE and WAIT) separate consecutive bursts.
- `pkt_ack` and `put` are never high in the same cycle.

## Configuration
- `ARB_STATS_EN` defined:
  - Each `grant_cnt[i]` increments on every cycle with `pkt_ack[i]`=1.
  - Counters saturate at all-ones (no wrap) and clear on reset.
- `ARB_STATS_EN` undefined:
  - No counter flops are instantiated.
  - `grant_cnt` is tied to 0, and the port list is unchanged.

## Structure
- Shared package `noc_pkg`:
  - `pkt_t` (32-bit packet)
  - arbiter state enum
  - `BYTES_PER_PKT`=4
- Sub-module `rr_picker`:
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and its index.
  - Purely combinational (a double-width priority scan).
- FSM, packet buffer, byte counter and stats counters live in `noc_out_arbiter`.

## Test plan
- Single request: port 2 valid with `pkt_in[2]`=32'hA1B2C3D4, `free`=1.
  - `pkt_ack`=4'b0100 in t.
  - `put` in t+2..t+5 with bytes A1, B2, C3, D4.
  - `gnt_id`=2.
- All four ports valid continuously from reset: grant order 0,1,2,3,0, each packet on a 6-cycle period.
- `free`=0 held for 10 cycles after ack: stays in WAIT with `put`=0 and `busy`=1. The first byte appears 1 cycle after `free` rises.
- `free` drops during SEND cnt=1: the burst still completes with all 4 bytes.
- Reset at cnt=2: `put`=0 and `payload`=0 at the next edge. A subsequent request from port 3 alone wins first, with the pointer reset.
- Stats (`ARB_STATS_EN`, `CNT_W`=4): 20 grants to port 1 gives `grant_cnt[1]`=4'hF, saturated. Without the macro it reads 0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared types and constants for the NoC output-port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package noc_pkg;

    // One NoC packet as presented by an input-buffer FIFO head.
    typedef logic [31:0] pkt_t;

    // Output-port arbiter FSM states.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WAIT = 2'd1,
        ARB_SEND = 2'd2
    } arb_state_e;

    localparam int BYTES_PER_PKT = 4;

    // Width of an index into n requesters, never narrower than one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/noc_out_arbiter_rr_picker.sv
// Round-robin picker: grants the first set request after ptr_i, wrapping modulo NUM_IN.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether to use the grant.
// Ports: req_i (request vector), ptr_i (last winner), gnt_oh_o (one-hot grant, 0 if
// no request), gnt_idx_o (index of the granted requester, 0 if no request).
module rr_picker
    import noc_pkg::*;
#(
    parameter  int NUM_IN = 4,
    localparam int IDW    = id_w(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req_i,
    input  logic [IDW-1:0]    ptr_i,
    output logic [NUM_IN-1:0] gnt_oh_o,
    output logic [IDW-1:0]    gnt_idx_o
);

    // Requests laid out twice so the wrap-around search becomes a straight scan
    // over positions ptr+1 .. ptr+NUM_IN.
    logic [2*NUM_IN-1:0] req_dbl;
    logic                found;

    assign req_dbl = {req_i, req_i};

    always_comb begin
        found     = 1'b0;
        gnt_idx_o = '0;
        for (int j = 0; j < 2*NUM_IN; j++) begin
            if (!found && (j > int'(ptr_i)) && (j <= int'(ptr_i) + NUM_IN) && req_dbl[j]) begin
                found     = 1'b1;
                gnt_idx_o = IDW'(j % NUM_IN);
            end
        end
        gnt_oh_o = found ? (NUM_IN'(1) << gnt_idx_o) : '0;
    end

endmodule

// File: rtl/noc_out_arbiter.sv
// Round-robin output-port arbiter: pops one input-buffer packet and serialises it as 4 bytes.
// Latency: ack in the request cycle, first byte 2 cycles later with free high, 6-cycle period.
// Backpressure: holds the packet in WAIT until free; free is ignored once the burst starts.
// Ports: clk/rst_b (sync active-low reset), pkt_in/pkt_valid/pkt_ack (input-buffer side),
// gnt_id/busy (status), free/put/payload (serial link), grant_cnt (per-port grant counters).
// Optional feature: define ARB_STATS_EN for saturating grant counters; otherwise grant_cnt is 0.
module noc_out_arbiter
    import noc_pkg::*;
#(
    parameter  int NUM_IN = 4,
    parameter  int CNT_W  = 16,
    localparam int IDW    = id_w(NUM_IN)
) (
    input  logic                         clk,
    input  logic                         rst_b,
    input  pkt_t [NUM_IN-1:0]            pkt_in,
    input  logic [NUM_IN-1:0]            pkt_valid,
    output logic [NUM_IN-1:0]            pkt_ack,
    output logic [IDW-1:0]               gnt_id,
    output logic                         busy,
    input  logic                         free,
    output logic                         put,
    output logic [7:0]                   payload,
    output logic [NUM_IN-1:0][CNT_W-1:0] grant_cnt
);

    arb_state_e          state_q, state_d;
    pkt_t                buf_q, buf_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [IDW-1:0]      gnt_q, gnt_d;
    logic [IDW-1:0]      ptr_q, ptr_d;
    logic [NUM_IN-1:0]   pick_oh;
    logic [IDW-1:0]      pick_idx;
    logic                take;

    rr_picker #(.NUM_IN(NUM_IN)) u_picker (
        .req_i     (pkt_valid),
        .ptr_i     (ptr_q),
        .gnt_oh_o  (pick_oh),
        .gnt_idx_o (pick_idx)
    );

    assign take   = (state_q == ARB_IDLE) && (|pkt_valid);
    assign gnt_id = gnt_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_b) state_q <= ARB_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: if (|pkt_valid) state_d = ARB_WAIT;
            ARB_WAIT: if (free)       state_d = ARB_SEND;
            ARB_SEND: if (cnt_q == 2'(BYTES_PER_PKT-1)) state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // Outputs. The ack is suppressed while reset is asserted so no packet is
    // popped that the reset would then throw away.
    always_comb begin
        pkt_ack = '0;
        busy    = 1'b0;
        put     = 1'b0;
        payload = 8'h00;
        case (state_q)
            ARB_IDLE: if (rst_b) pkt_ack = pick_oh;
            ARB_WAIT: busy = 1'b1;
            ARB_SEND: begin
                busy    = 1'b1;
                put     = 1'b1;
                // Most significant byte goes out first.
                payload = buf_q[8*(BYTES_PER_PKT-1-int'(cnt_q)) +: 8];
            end
            default: ;
        endcase
    end

    // Packet buffer, byte counter, winner and pointer
    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        gnt_d = gnt_q;
        ptr_d = ptr_q;
        if (take) begin
            buf_d = pkt_in[pick_idx];
            gnt_d = pick_idx;
            ptr_d = pick_idx;
        end
        // The 2-bit counter wraps to 0 on the last byte, ready for the next burst.
        if (state_q == ARB_SEND) cnt_d = cnt_q + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            buf_q <= '0;
            cnt_q <= '0;
            gnt_q <= '0;
            // Pointer at the last port so port 0 is searched first.
            ptr_q <= IDW'(NUM_IN-1);
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
            gnt_q <= gnt_d;
            ptr_q <= ptr_d;
        end
    end

`ifdef ARB_STATS_EN
    logic [NUM_IN-1:0][CNT_W-1:0] stat_q;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            stat_q <= '0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                // Saturate at all-ones rather than wrap.
                if (pkt_ack[i] && (stat_q[i] != {CNT_W{1'b1}}))
                    stat_q[i] <= stat_q[i] + CNT_W'(1);
            end
        end
    end

    assign grant_cnt = stat_q;
`else
    assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_noc_out_arbiter.sv
// Self-checking bench for noc_out_arbiter (NUM_IN=4, CNT_W=4).
// Latency: n/a.
// Backpressure: drives free directly, including stalls and mid-burst drops.
module tb_noc_out_arbiter;
    import noc_pkg::*;

    localparam int N  = 4;
    localparam int CW = 4;

    logic                 clk = 1'b0;
    logic                 rst_b;
    pkt_t [N-1:0]         pkt_in;
    logic [N-1:0]         pkt_valid;
    logic [N-1:0]         pkt_ack;
    logic [1:0]           gnt_id;
    logic                 busy;
    logic                 free;
    logic                 put;
    logic [7:0]           payload;
    logic [N-1:0][CW-1:0] grant_cnt;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    noc_out_arbiter #(.NUM_IN(N), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .pkt_in    (pkt_in),
        .pkt_valid (pkt_valid),
        .pkt_ack   (pkt_ack),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .free      (free),
        .put       (put),
        .payload   (payload),
        .grant_cnt (grant_cnt)
    );

    // Reference rules

    // Round-robin: first valid port after the last winner, wrapping.
    function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
        for (int k = 1; k <= N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Expected grant counter value after a number of grants.
    function automatic int exp_stat(input int grants);
`ifdef ARB_STATS_EN
        return (grants > 15) ? 15 : grants;
`else
        return (grants > 0) ? 0 : 0;
`endif
    endfunction

    function automatic logic [7:0] byte_of(input pkt_t p, input int b);
        return p[31-8*b -: 8];
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_b     = 1'b0;
        pkt_valid = '0;
        free      = 1'b1;
        cyc();
        cyc();
        rst_b = 1'b1;
    endtask

    task automatic test_reset();
        rst_b     = 1'b0;
        pkt_valid = '1;
        free      = 1'b1;
        for (int i = 0; i < N; i++) pkt_in[i] = $urandom;
        cyc();
        cyc();
        #1;
        vectors++; if (put !== 1'b0) begin errors++; $display("FAIL reset_put got %0b want 0", put); end
        vectors++; if (payload !== 8'h00) begin errors++; $display("FAIL reset_payload got %h want 00", payload); end
        vectors++; if (pkt_ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got %b want 0000", pkt_ack); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        vectors++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL reset_gnt_id got %0d want 0", gnt_id); end
        vectors++; if (grant_cnt !== '0) begin errors++; $display("FAIL reset_grant_cnt got %h want 0", grant_cnt); end
    endtask

    task automatic test_single();
        pkt_t p;
        p = 32'hA1B2C3D4;
        do_reset();
        pkt_in[2] = p;
        pkt_valid = 4'b0100;
        free      = 1'b1;
        #1;
        vectors++; if (pkt_ack !== 4'b0100) begin errors++; $display("FAIL single_ack got %b want 0100", pkt_ack); end
        cyc();
        pkt_valid = '0;
        #1;
        vectors++; if (busy !== 1'b1 || put !== 1'b0) begin errors++; $display("FAIL single_wait busy=%0b put=%0b want 1/0", busy, put); end
        vectors++; if (gnt_id !== 2'd2) begin errors++; $display("FAIL single_gnt_id got %0d want 2", gnt_id); end
        for (int b = 0; b < 4; b++) begin
            cyc();
            #1;
            vectors++; if (put !== 1'b1 || payload !== byte_of(p, b)) begin
                errors++; $display("FAIL single_byte%0d put=%0b payload=%h want 1/%h", b, put, payload, byte_of(p, b));
            end
            vectors++; if (pkt_ack !== 4'b0000) begin errors++; $display("FAIL single_ack_during_put got %b want 0000", pkt_ack); end
        end
        cyc();
        #1;
        vectors++; if (busy !== 1'b0 || put !== 1'b0 || payload !== 8'h00) begin
            errors++; $display("FAIL single_idle busy=%0b put=%0b payload=%h want 0/0/00", busy, put, payload);
        end
    endtask

    task automatic test_all_valid();
        logic [N-1:0] exp_ack;
        int           w;
        do_reset();
        for (int i = 0; i < N; i++) pkt_in[i] = $urandom;
        pkt_valid = '1;
        free      = 1'b1;
        for (int c = 0; c < 30; c++) begin
            #1;
            w       = (c / 6) % 4;
            exp_ack = (c % 6 == 0) ? (4'(1) << w) : 4'b0000;
            vectors++; if (pkt_ack !== exp_ack) begin errors++; $display("FAIL all_valid_ack c=%0d got %b want %b", c, pkt_ack, exp_ack); end
            if (c % 6 >= 2) begin
                vectors++; if (put !== 1'b1 || payload !== byte_of(pkt_in[w], c % 6 - 2)) begin
                    errors++; $display("FAIL all_valid_byte c=%0d put=%0b payload=%h want 1/%h", c, put, payload, byte_of(pkt_in[w], c % 6 - 2));
                end
            end
            cyc();
        end
        pkt_valid = '0;
    endtask

    task automatic test_free_stall();
        pkt_t p;
        do_reset();
        p         = $urandom;
        pkt_in[1] = p;
        pkt_valid = 4'b0010;
        free      = 1'b0;
        #1;
        vectors++; if (pkt_ack !== 4'b0010) begin errors++; $display("FAIL stall_ack got %b want 0010", pkt_ack); end
        cyc();
        pkt_valid = '0;
        for (int k = 0; k < 10; k++) begin
            #1;
            vectors++; if (put !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL stall_wait k=%0d put=%0b busy=%0b want 0/1", k, put, busy);
            end
            cyc();
        end
        free = 1'b1;
        #1;
        vectors++; if (put !== 1'b0) begin errors++; $display("FAIL stall_free_rise put got %0b want 0", put); end
        cyc();
        #1;
        vectors++; if (put !== 1'b1 || payload !== byte_of(p, 0)) begin
            errors++; $display("FAIL stall_first_byte put=%0b payload=%h want 1/%h", put, payload, byte_of(p, 0));
        end
    endtask

    task automatic test_free_drop();
        pkt_t p;
        do_reset();
        p         = $urandom;
        pkt_in[3] = p;
        pkt_valid = 4'b1000;
        free      = 1'b1;
        #1;
        vectors++; if (pkt_ack !== 4'b1000) begin errors++; $display("FAIL drop_ack got %b want 1000", pkt_ack); end
        cyc();
        pkt_valid = '0;
        cyc();
        for (int b = 0; b < 4; b++) begin
            if (b >= 1) free = 1'b0;
            #1;
            vectors++; if (put !== 1'b1 || payload !== byte_of(p, b)) begin
                errors++; $display("FAIL drop_byte%0d put=%0b payload=%h want 1/%h", b, put, payload, byte_of(p, b));
            end
            cyc();
        end
        #1;
        vectors++; if (put !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL drop_end put=%0b busy=%0b want 0/0", put, busy); end
        free = 1'b1;
    endtask

    task automatic test_reset_mid();
        pkt_t p;
        do_reset();
        p         = $urandom;
        pkt_in[2] = p;
        pkt_valid = 4'b0100;
        free      = 1'b1;
        cyc();
        pkt_valid = '0;
        cyc();
        cyc();
        cyc();
        #1;
        vectors++; if (put !== 1'b1 || payload !== byte_of(p, 2)) begin
            errors++; $display("FAIL rstmid_cnt2 put=%0b payload=%h want 1/%h", put, payload, byte_of(p, 2));
        end
        rst_b = 1'b0;
        cyc();
        #1;
        vectors++; if (put !== 1'b0 || payload !== 8'h00 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_drop put=%0b payload=%h busy=%0b want 0/00/0", put, payload, busy);
        end
        rst_b = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            #1;
            vectors++; if (put !== 1'b0) begin errors++; $display("FAIL rstmid_no_resend k=%0d put got %0b want 0", k, put); end
        end
        pkt_in[3] = $urandom;
        pkt_valid = 4'b1000;
        #1;
        vectors++; if (pkt_ack !== 4'b1000) begin errors++; $display("FAIL rstmid_port3_ack got %b want 1000", pkt_ack); end
        cyc();
        pkt_valid = '0;
        #1;
        vectors++; if (gnt_id !== 2'd3) begin errors++; $display("FAIL rstmid_port3_gnt got %0d want 3", gnt_id); end
    endtask

    task automatic test_stats();
        do_reset();
        pkt_in[1] = $urandom;
        pkt_valid = 4'b0010;
        free      = 1'b1;
        for (int c = 0; c < 120; c++) cyc();
        pkt_valid = '0;
        #1;
        vectors++; if (grant_cnt[1] !== 4'(exp_stat(20))) begin
            errors++; $display("FAIL stats_port1 got %h want %h", grant_cnt[1], 4'(exp_stat(20)));
        end
        vectors++; if (grant_cnt[0] !== 4'h0) begin errors++; $display("FAIL stats_port0 got %h want 0", grant_cnt[0]); end
    endtask

    // Randomised traffic against a timeline model: phase 0 idle, 1 waiting for
    // free, 2..5 sending bytes 0..3.
    task automatic test_random();
        int           phase;
        int           mptr;
        int           mgnt;
        int           w;
        int           grants [N];
        pkt_t         mpkt;
        logic [N-1:0] exp_ack;
        logic         exp_put;
        logic [7:0]   exp_pay;
        do_reset();
        phase = 0;
        mptr  = N - 1;
        mgnt  = 0;
        mpkt  = '0;
        for (int i = 0; i < N; i++) grants[i] = 0;
        for (int c = 0; c < 400; c++) begin
            pkt_valid = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom);
            for (int i = 0; i < N; i++) pkt_in[i] = $urandom;
            free = ($urandom_range(0, 3) != 0);
            #1;
            w       = (phase == 0) ? rr_pick(pkt_valid, mptr) : -1;
            exp_ack = (w >= 0) ? (4'(1) << w) : 4'b0000;
            exp_put = (phase >= 2);
            exp_pay = exp_put ? mpkt[8*(5-phase) +: 8] : 8'h00;
            vectors++; if (pkt_ack !== exp_ack) begin errors++; $display("FAIL rand_ack c=%0d got %b want %b", c, pkt_ack, exp_ack); end
            vectors++; if (put !== exp_put) begin errors++; $display("FAIL rand_put c=%0d got %0b want %0b", c, put, exp_put); end
            vectors++; if (payload !== exp_pay) begin errors++; $display("FAIL rand_payload c=%0d got %h want %h", c, payload, exp_pay); end
            vectors++; if (busy !== (phase != 0)) begin errors++; $display("FAIL rand_busy c=%0d got %0b want %0b", c, busy, phase != 0); end
            vectors++; if (gnt_id !== 2'(mgnt)) begin errors++; $display("FAIL rand_gnt_id c=%0d got %0d want %0d", c, gnt_id, mgnt); end
            case (phase)
                0: if (w >= 0) begin
                    mpkt = pkt_in[w];
                    mgnt = w;
                    mptr = w;
                    grants[w]++;
                    phase = 1;
                end
                1: if (free) phase = 2;
                5: phase = 0;
                default: phase++;
            endcase
            cyc();
        end
        pkt_valid = '0;
        #1;
        for (int i = 0; i < N; i++) begin
            vectors++; if (grant_cnt[i] !== 4'(exp_stat(grants[i]))) begin
                errors++; $display("FAIL rand_grant_cnt%0d got %h want %h", i, grant_cnt[i], 4'(exp_stat(grants[i])));
            end
        end
    endtask

    initial begin
        rst_b     = 1'b0;
        pkt_valid = '0;
        pkt_in    = '0;
        free      = 1'b1;
        test_reset();
        test_single();
        test_all_valid();
        test_free_stall();
        test_free_drop();
        test_reset_mid();
        test_stats();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
